// File: rtl/spike_pkg.sv
// Shared constants, FSM state encoding and word-count helper for the spike raster packer.
package spike_pkg;

  localparam logic [15:0] HDR_FLAG = 16'h8000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_HDR   = 3'd2,
    ST_TS    = 3'd3,
    ST_DATA  = 3'd4
  } state_t;

  function automatic int unsigned nwords(input int unsigned nch);
    return (nch + 32'd15) / 32'd16;
  endfunction

endpackage

// File: rtl/spike_fifo.sv
// Single-clock first-word-fall-through FIFO, 16 bits wide, DEPTH words (power of 2).
// Reads on an empty FIFO are ignored and the output reads as zero while empty.
module spike_fifo #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     reset_global,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [15:0]              din,
  input  logic                     rd_en,
  output logic [15:0]              dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [15:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_empty;
  logic          w_full;
  logic          w_rd;
  logic          w_wr;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_rd    = rd_en && !w_empty;
  assign w_wr    = wr_en && (!w_full || w_rd);

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && !clear) r_mem[r_wptr] <= din;
  end

  assign dout  = w_empty ? '0 : r_mem[r_rptr];
  assign count = r_count;

endmodule

// File: rtl/spike_raster_packer.sv
// Multi-channel spike-raster packer: one {header, [timestamp], bitmap} frame per tick into a pipe-out FIFO.
// Optional timestamp word enabled by defining SPIKE_PACKER_TIMESTAMP_EN.
module spike_raster_packer
  import spike_pkg::*;
#(
  parameter int unsigned NCH       = 16,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned BLOCK_LEN = 256
) (
  input  logic                   clk,
  input  logic                   reset_global,
  input  logic                   clear,
  input  logic                   tick,
  input  logic [NCH-1:0]         spikes,
  input  logic                   ep_read,
  output logic [15:0]            ep_datain,
  output logic                   ep_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [15:0]            drop_cnt,
  output logic [15:0]            overrun_cnt,
  output logic                   underflow
);

  localparam int unsigned NW = nwords(NCH);
  localparam int unsigned PW = NW * 16;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
`ifdef SPIKE_PACKER_TIMESTAMP_EN
  localparam int unsigned FRAME_LEN = NW + 2;
`else
  localparam int unsigned FRAME_LEN = NW + 1;
`endif

  state_t         r_state;
  logic [NCH-1:0] r_acc;
  logic [NCH-1:0] r_cur_snap;
  logic [NCH-1:0] r_pend_snap;
  logic           r_pending;
  logic [14:0]    r_seq;
  logic [7:0]     r_widx;
  logic [15:0]    r_drop;
  logic [15:0]    r_ovr;
  logic           r_under;
  logic           r_ready;

  logic [NCH-1:0] w_snap;
  logic [PW-1:0]  w_pad;
  logic [CW-1:0]  w_free;
  logic           w_rd_ok;
  logic           w_wr_en;
  logic [15:0]    w_din;

  assign w_snap  = r_acc | spikes;
  assign w_pad   = PW'(r_cur_snap);
  assign w_rd_ok = ep_read && !clear && (fifo_count != '0);
  // A read in the CHECK cycle frees its slot before the frame's first write lands.
  assign w_free  = CW'(DEPTH) - fifo_count + CW'(w_rd_ok);

`ifdef SPIKE_PACKER_TIMESTAMP_EN
  logic [15:0] r_tick_cnt;
  logic [15:0] r_cur_ts;
  logic [15:0] r_pend_ts;

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      r_tick_cnt <= '0;
      r_cur_ts   <= '0;
      r_pend_ts  <= '0;
    end else if (clear) begin
      r_tick_cnt <= '0;
      r_cur_ts   <= '0;
      r_pend_ts  <= '0;
    end else begin
      if (r_state == ST_IDLE && r_pending) r_cur_ts <= r_pend_ts;
      if (tick) begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
        if (r_state == ST_IDLE && !r_pending) r_cur_ts  <= r_tick_cnt;
        else if (r_state == ST_IDLE)          r_pend_ts <= r_tick_cnt;
        else if (!r_pending)                  r_pend_ts <= r_tick_cnt;
      end
    end
  end
`endif

  always_comb begin
    w_wr_en = 1'b0;
    w_din   = '0;
    if (!clear) begin
      case (r_state)
        ST_HDR: begin
          w_wr_en = 1'b1;
          w_din   = HDR_FLAG | 16'(r_seq);
        end
`ifdef SPIKE_PACKER_TIMESTAMP_EN
        ST_TS: begin
          w_wr_en = 1'b1;
          w_din   = r_cur_ts;
        end
`endif
        ST_DATA: begin
          w_wr_en = 1'b1;
          w_din   = w_pad[{r_widx, 4'b0000} +: 16];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      r_acc <= '0;
    end else if (clear || tick) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_snap;
    end
  end

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      r_state     <= ST_IDLE;
      r_cur_snap  <= '0;
      r_pend_snap <= '0;
      r_pending   <= 1'b0;
      r_seq       <= '0;
      r_widx      <= '0;
      r_drop      <= '0;
      r_ovr       <= '0;
    end else if (clear) begin
      r_state     <= ST_IDLE;
      r_cur_snap  <= '0;
      r_pend_snap <= '0;
      r_pending   <= 1'b0;
      r_seq       <= '0;
      r_widx      <= '0;
      r_drop      <= '0;
      r_ovr       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A held snapshot is older than any tick arriving now, so it goes first.
          if (r_pending) begin
            r_cur_snap <= r_pend_snap;
            r_state    <= ST_CHECK;
            r_pending  <= tick;
            if (tick) r_pend_snap <= w_snap;
          end else if (tick) begin
            r_cur_snap <= w_snap;
            r_state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_free >= CW'(FRAME_LEN)) begin
            r_state <= ST_HDR;
          end else begin
            r_state <= ST_IDLE;
            r_seq   <= r_seq + 1'b1;
            if (r_drop != 16'hFFFF) r_drop <= r_drop + 1'b1;
          end
        end
        ST_HDR: begin
          r_seq  <= r_seq + 1'b1;
          r_widx <= '0;
`ifdef SPIKE_PACKER_TIMESTAMP_EN
          r_state <= ST_TS;
`else
          r_state <= ST_DATA;
`endif
        end
        ST_TS: r_state <= ST_DATA;
        ST_DATA: begin
          r_widx <= r_widx + 1'b1;
          if (r_widx == 8'(NW - 1)) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (tick && r_state != ST_IDLE) begin
        if (r_pending) begin
          if (r_ovr != 16'hFFFF) r_ovr <= r_ovr + 1'b1;
        end else begin
          r_pend_snap <= w_snap;
          r_pending   <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      r_under <= 1'b0;
      r_ready <= 1'b0;
    end else if (clear) begin
      r_under <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      if (ep_read && fifo_count == '0) r_under <= 1'b1;
      r_ready <= (32'(fifo_count) >= BLOCK_LEN);
    end
  end

  spike_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset_global (reset_global),
    .clear        (clear),
    .wr_en        (w_wr_en),
    .din          (w_din),
    .rd_en        (w_rd_ok),
    .dout         (ep_datain),
    .count        (fifo_count)
  );

  assign ep_ready    = r_ready;
  assign drop_cnt    = r_drop;
  assign overrun_cnt = r_ovr;
  assign underflow   = r_under;

endmodule

// File: tb/tb_spike_raster_packer.sv
// Bench for spike_raster_packer: frame-level reference model compared every cycle, plus literal frame checks.
module tb_spike_raster_packer;

`ifdef SPIKE_PACKER_TIMESTAMP_EN
  localparam int TSW = 1;
`else
  localparam int TSW = 0;
`endif
  localparam int FL0 = 2 + TSW;
  localparam int FL1 = 3 + TSW;

  logic clk = 1'b0;
  logic rst;
  logic tick0, rd0, clr0, tick1, rd1, clr1;
  logic [15:0] spk0;
  logic [19:0] spk1;
  logic [15:0] d0, d1, drop0, drop1, ovr0, ovr1;
  logic rdy0, rdy1, und0, und1;
  logic [4:0] cnt0;
  logic [6:0] cnt1;

  always #5 clk = ~clk;

  spike_raster_packer #(.NCH(16), .DEPTH(16), .BLOCK_LEN(4)) u0 (
    .clk(clk), .reset_global(rst), .clear(clr0), .tick(tick0), .spikes(spk0), .ep_read(rd0),
    .ep_datain(d0), .ep_ready(rdy0), .fifo_count(cnt0), .drop_cnt(drop0), .overrun_cnt(ovr0),
    .underflow(und0));

  spike_raster_packer #(.NCH(20), .DEPTH(64), .BLOCK_LEN(8)) u1 (
    .clk(clk), .reset_global(rst), .clear(clr1), .tick(tick1), .spikes(spk1), .ep_read(rd1),
    .ep_datain(d1), .ep_ready(rdy1), .fifo_count(cnt1), .drop_cnt(drop1), .overrun_cnt(ovr1),
    .underflow(und1));

  int n_checks = 0;
  int n_err = 0;

  function automatic void chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int dep(input int i); return (i == 0) ? 16 : 64; endfunction
  function automatic int blen(input int i); return (i == 0) ? 4 : 8; endfunction
  function automatic int nwd(input int i); return (i == 0) ? 1 : 2; endfunction
  function automatic int flen(input int i); return nwd(i) + 1 + TSW; endfunction

  // Reference model: frames are whole units; a frame started in cycle s has its
  // space check in s+1 and its words land at the ends of s+2 .. s+1+FRAME_LEN.
  logic [15:0] mq [2][$];
  int m_drop[2], m_ovr[2], m_seq[2], m_tc[2], m_start[2], m_cts[2], m_pts[2];
  bit m_und[2], m_rdy[2], m_act[2], m_pend[2];
  logic [31:0] m_acc[2], m_cur[2], m_pv[2];
  logic [15:0] m_fw[2][8];
  int cyc = 0;

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      bit tk, rd, cl, was_idle;
      logic [31:0] sp, snap;
      int sz0, k, o;
      tk = (i == 0) ? tick0 : tick1;
      rd = (i == 0) ? rd0 : rd1;
      cl = (i == 0) ? clr0 : clr1;
      sp = (i == 0) ? 32'(spk0) : 32'(spk1);
      if (rst || cl) begin
        mq[i].delete();
        m_drop[i] = 0; m_ovr[i] = 0; m_seq[i] = 0; m_tc[i] = 0;
        m_und[i] = 0; m_rdy[i] = 0; m_act[i] = 0; m_pend[i] = 0;
        m_acc[i] = '0;
      end else begin
        sz0 = mq[i].size();
        if (rd) begin
          if (sz0 > 0) void'(mq[i].pop_front());
          else m_und[i] = 1;
        end
        was_idle = !m_act[i];
        if (m_act[i]) begin
          k = cyc - m_start[i];
          if (k == 1) begin
            if (dep(i) - mq[i].size() >= flen(i)) begin
              m_fw[i][0] = 16'h8000 | 16'(m_seq[i]);
              o = 1;
              if (TSW == 1) begin m_fw[i][1] = 16'(m_cts[i]); o = 2; end
              for (int j = 0; j < nwd(i); j++) m_fw[i][o + j] = m_cur[i][16*j +: 16];
            end else begin
              if (m_drop[i] < 65535) m_drop[i]++;
              m_act[i] = 0;
            end
            m_seq[i] = (m_seq[i] + 1) % 32768;
          end else if (k >= 2) begin
            mq[i].push_back(m_fw[i][k - 2]);
            if (k == flen(i) + 1) m_act[i] = 0;
          end
        end
        snap = m_acc[i] | sp;
        if (was_idle) begin
          if (m_pend[i]) begin
            m_act[i] = 1; m_start[i] = cyc; m_cur[i] = m_pv[i]; m_cts[i] = m_pts[i];
            if (tk) begin m_pv[i] = snap; m_pts[i] = m_tc[i]; end
            else m_pend[i] = 0;
          end else if (tk) begin
            m_act[i] = 1; m_start[i] = cyc; m_cur[i] = snap; m_cts[i] = m_tc[i];
          end
        end else if (tk) begin
          if (m_pend[i]) begin
            if (m_ovr[i] < 65535) m_ovr[i]++;
          end else begin
            m_pend[i] = 1; m_pv[i] = snap; m_pts[i] = m_tc[i];
          end
        end
        if (tk) begin m_acc[i] = '0; m_tc[i] = (m_tc[i] + 1) % 65536; end
        else m_acc[i] = snap;
        m_rdy[i] = (sz0 >= blen(i));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("u0_datain", d0, (mq[0].size() > 0) ? mq[0][0] : 16'h0);
    chk("u0_count", cnt0, mq[0].size());
    chk("u0_ready", rdy0, m_rdy[0]);
    chk("u0_drop", drop0, m_drop[0]);
    chk("u0_overrun", ovr0, m_ovr[0]);
    chk("u0_underflow", und0, m_und[0]);
    chk("u1_datain", d1, (mq[1].size() > 0) ? mq[1][0] : 16'h0);
    chk("u1_count", cnt1, mq[1].size());
    chk("u1_ready", rdy1, m_rdy[1]);
    chk("u1_drop", drop1, m_drop[1]);
    chk("u1_overrun", ovr1, m_ovr[1]);
    chk("u1_underflow", und1, m_und[1]);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic tick_u0(); tick0 = 1; @(negedge clk); tick0 = 0; endtask
  task automatic read_u0(input int n);
    rd0 = 1; repeat (n) @(negedge clk); rd0 = 0;
  endtask
  task automatic read_u1(input int n);
    rd1 = 1; repeat (n) @(negedge clk); rd1 = 0;
  endtask
  task automatic clear_u0(); clr0 = 1; @(negedge clk); clr0 = 0; endtask

  initial begin
    int stored;
    rst = 1; tick0 = 0; rd0 = 0; clr0 = 0; spk0 = '0;
    tick1 = 0; rd1 = 0; clr1 = 0; spk1 = '0;
    repeat (3) @(negedge clk);
    chk("lit_rst_datain", d0, 16'h0);
    chk("lit_rst_count", cnt0, 0);
    chk("lit_rst_ready", rdy0, 0);
    rst = 0;
    @(negedge clk);

    // Spike on channel 3 well before the tick is accumulated into frame 0
    spk0 = 16'h0008; @(negedge clk); spk0 = '0;
    repeat (2) @(negedge clk);
    tick_u0();
    repeat (6) @(negedge clk);
    chk("lit_f0_count", cnt0, FL0);
    chk("lit_f0_hdr", d0, 16'h8000);
    read_u0(1 + TSW);
    chk("lit_f0_data", d0, 16'h0008);
    read_u0(1);
    chk("lit_f0_drained", cnt0, 0);
    tick_u0();
    repeat (6) @(negedge clk);
    chk("lit_f1_hdr", d0, 16'h8001);
    read_u0(1 + TSW);
    chk("lit_f1_data", d0, 16'h0000);
    chk("lit_f1_count", cnt0, 1);
    read_u0(1);

    // NCH=20: spikes only in the tick cycle, top channel lands in word 1
    spk1 = 20'h80001; tick1 = 1; @(negedge clk); spk1 = '0; tick1 = 0;
    repeat (6) @(negedge clk);
    chk("lit_n20_count", cnt1, FL1);
    chk("lit_n20_hdr", d1, 16'h8000);
    read_u1(1 + TSW);
    chk("lit_n20_w0", d1, 16'h0001);
    read_u1(1);
    chk("lit_n20_w1", d1, 16'h0008);
    read_u1(1);

    // Three back-to-back ticks
    tick0 = 1; repeat (3) @(negedge clk); tick0 = 0;
    repeat (12) @(negedge clk);
    chk("lit_ovr_cnt", ovr0, 1);
    chk("lit_ovr_count", cnt0, 2 * FL0);
    chk("lit_ovr_hdr", d0, 16'h8002);
    chk("lit_ready_hi", rdy0, 1);
    tick_u0();
    repeat (8) @(negedge clk);
    read_u0(5);
    chk("lit_rd5_under", und0, 0);
    chk("lit_rd5_count", cnt0, 3 * FL0 - 5);
    read_u0(3 * FL0 - 5);
    chk("lit_rdall_under", und0, 0);
    read_u0(1);
    chk("lit_empty_under", und0, 1);
    chk("lit_empty_datain", d0, 16'h0);
    clear_u0();
    chk("lit_clr_under", und0, 0);
    chk("lit_clr_ovr", ovr0, 0);
    chk("lit_clr_ready", rdy0, 0);

    // Fill the 16-word FIFO without reading
    for (int k = 0; k < 9; k++) begin
      spk0 = 16'(1 << k); tick0 = 1; @(negedge clk); tick0 = 0; spk0 = '0;
      repeat (5) @(negedge clk);
    end
    stored = 16 / FL0;
    chk("lit_full_count", cnt0, stored * FL0);
    chk("lit_full_drop", drop0, 9 - stored);
    read_u0(FL0);
    tick_u0();
    repeat (8) @(negedge clk);
    read_u0(stored * FL0 - FL0);
    chk("lit_seq9_hdr", d0, 16'h8009);
    clear_u0();
    chk("lit_clr2_drop", drop0, 0);

    // clear while a frame is being written
    tick_u0();
    repeat (2) @(negedge clk);
    clear_u0();
    chk("lit_midclr_count", cnt0, 0);
    chk("lit_midclr_datain", d0, 16'h0);
    tick_u0();
    repeat (6) @(negedge clk);
    chk("lit_postclr_hdr", d0, 16'h8000);

    // async reset in the middle of a frame
    tick_u0();
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    chk("lit_midrst_count", cnt0, 0);
    chk("lit_midrst_datain", d0, 16'h0);
    chk("lit_midrst_ready", rdy0, 0);
    chk("lit_midrst_ovr", ovr0, 0);
    rst = 0;
    @(negedge clk);
    tick_u0();
    repeat (6) @(negedge clk);
    chk("lit_postrst_hdr", d0, 16'h8000);
    read_u0(FL0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/spike_raster_packer.md
# spike_raster_packer

Parametrised multi-channel spike-raster packer for the XEM6010 neural-sim designs. It collects spikes from NCH channels between simulation ticks and forms one frame per tick. Each frame holds a sequence header and the channel bitmap. Frames are buffered in a FIFO drained by an okBTPipeOut endpoint. It replaces the fixed three-channel, one-word-per-read spike packing with lossless, sequence-numbered, block-ready frames.

## Interface
Parameters:
- NCH, 16, number of spike channels (1–256)
- DEPTH, 1024, FIFO depth in 16-bit words (power of 2)
- BLOCK_LEN, 256, words per pipe block; ep_ready threshold

Ports:
- clk  in  1  system clock (ti_clk domain); all inputs synchronous to it
- reset_global  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous flush: empties FIFO, zeroes seq, accumulator, counters
- tick  in  1  one-cycle pulse marking end of a sim step
- spikes  in  NCH  per-channel spike level, sampled every clk
- ep_read  in  1  pipe-out read strobe, pops one word
- ep_datain  out  16  FIFO head word
- ep_ready  out  1  fifo_count ≥ BLOCK_LEN
- fifo_count  out  $clog2(DEPTH)+1  words stored
- drop_cnt  out  16  frames dropped for lack of space, saturating
- overrun_cnt  out  16  ticks lost while busy, saturating
- underflow  out  1  sticky: ep_read seen while empty

## Operation
- NW = ceil(NCH/16) data words. FRAME_LEN = NW+1, or NW+2 with timestamp.
- Accumulator acc[NCH-1:0] is updated each cycle as acc |= spikes.
- On tick: snap = acc | spikes, and acc clears. A spike in the tick cycle belongs to the closing frame.
- Header word: {1'b1, seq[14:0]}. seq increments per emitted or dropped frame and wraps at 32767→0.
- Data word k: snap[16k+15:16k], zero-padded above NCH. Word 0 is emitted first.
- FSM states:
  - IDLE: on a tick or with pending set, go to CHECK.
  - CHECK: if free space ≥ FRAME_LEN, go to HDR. Otherwise increment drop_cnt, increment seq, return to IDLE.
  - HDR: go to TS when timestamp is enabled, else DATA.
  - TS: go to DATA.
  - DATA: write NW words, then go to IDLE.
- Free space is evaluated in CHECK and includes any read occurring in that cycle. A frame is never partially written.
- Tick while not IDLE: snap goes to pend_snap and pending=1. A tick while pending is already set increments overrun_cnt and discards that snapshot.
- ep_read pops the head. ep_datain shows the new head on the next cycle. ep_read when empty leaves the FIFO unchanged, drives 16'h0000 and sets underflow.
- Simultaneous write and read: count is unchanged. Full and empty never occur mid-frame because of the CHECK gate.
- clear has priority over tick and ep_read. It returns the FSM to IDLE and drops any in-flight frame.

## Timing
- Reset values: ep_datain 0, ep_ready 0, fifo_count 0, drop_cnt 0, overrun_cnt 0, underflow 0. FSM resets to IDLE, seq to 0, acc to 0.
- Tick at cycle t with FSM in IDLE:
  - CHECK at t+1.
  - Header written at t+2.
  - Last word written at t+1+FRAME_LEN.
  - Header visible on ep_datain at t+3 if FIFO was empty.
- Minimum tick spacing for zero overrun: FRAME_LEN+2 cycles.
- ep_ready is registered and reflects fifo_count one cycle later.
- Counters saturate at 16'hFFFF.

## Configuration
- SPIKE_PACKER_TIMESTAMP_EN defined:
  - A 16-bit free-running tick counter word follows the header.
  - The counter increments on every tick, including dropped or overrun ticks, and clears on clear.
  - FRAME_LEN = NW+2.
- Undefined: there is no TS state, no counter, and FRAME_LEN = NW+1.

## Structure
- Package spike_pkg holds:
  - HDR_FLAG constant (16'h8000)
  - FSM state enum
  - function nwords(nch) returning ceil(nch/16)
- Sub-module spike_fifo: single-clock FWFT FIFO, 16 bits by DEPTH. Interface is wr_en/din/rd_en/dout/count, with an empty-read guard.
- Top level holds the accumulator, snapshot/pending registers, FSM, seq and counters.

## Test plan
- NCH=16, spikes[3] pulsed once, then a tick → FIFO receives 16'h8000 and 16'h0008. The next tick with no spikes gives 16'h8001 and 16'h0000.
- NCH=20, spikes[19] and spikes[0] high in the tick cycle only → data words 16'h0001 and 16'h0008.
- DEPTH=16, NCH=16, no reads, 9 ticks → 8 frames stored, fifo_count=16, drop_cnt=1. A tenth frame's header carries seq 9.
- Ticks on consecutive cycles (3 in a row) while IDLE → frames 0 and 1 emitted, overrun_cnt=1.
- BLOCK_LEN=4: after 2 frames ep_ready=1. Reading 5 words → underflow stays 0. A read on an empty FIFO → underflow=1 and ep_datain=0.
- clear asserted during DATA, and reset_global asserted mid-frame → all outputs return to their reset values. The next frame header is 16'h8000.
